// File: rtl/pipeline_stage2.sv
// Stage 2 of the microcoded pipeline: registers the stage-1 control word, runs the ALU and decodes transfer-bus enables.
// Optional feature: define STAGE2_FLAG_BYPASS_EN to expose next-flag values combinationally on the ALU flag outputs.
module pipeline_stage2 #(
  parameter int WIDTH             = 8,
  parameter int RESET_HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [15:0]      controls_in,
  input  logic [7:0]       instruction_in,
  input  logic [WIDTH-1:0] lhs_data,
  input  logic [WIDTH-1:0] rhs_data,
  output logic [1:0]       lhs_select,
  output logic [1:0]       rhs_select,
  output logic [WIDTH-1:0] alu_result,
  output logic [15:0]      load_enable,
  output logic [7:0]       assert_enable,
  output logic             fetch_suppress,
  output logic [7:0]       instruction_out,
  output logic             flag_overflow,
  output logic             flag_sign,
  output logic             flag_zero,
  output logic             flag_acarry,
  output logic             flag_lcarry,
  output logic             flag_pcraflip,
  output logic             flag_reset
);

  typedef enum logic [3:0] {
    OpPass, OpAdd, OpAdc, OpSub, OpSbc, OpAnd, OpOr, OpXor,
    OpNot, OpShl, OpShr, OpRol, OpRor, OpInc, OpDec, OpCmp
  } aluOpE;

  aluOpE            aluOp_q;
  logic [3:0]       xferLoad_q;
  logic [2:0]       xferAssert_q;
  logic             fetch_q;
  logic [7:0]       instr_q;
  logic [WIDTH-1:0] lhs_q, rhs_q;
  logic             ov_q, sign_q, zero_q, ac_q, lc_q, pcra_q, frst_q;
  logic [3:0]       holdCnt_q;

  logic [WIDTH-1:0] addB, result, flagSrc;
  logic [WIDTH:0]   sum;
  logic             addC, isArith, isLogic, lcOut, aluOv;
  logic             ov_d, sign_d, zero_d, ac_d, lc_d, updateFlags;

  assign lhs_select = controls_in[1:0];
  assign rhs_select = controls_in[3:2];

  // Subtract-style ops run through the same adder with an inverted RHS, so acarry=1 means no borrow.
  always_comb begin
    addB    = '0;
    addC    = 1'b0;
    isArith = 1'b0;
    isLogic = 1'b0;
    lcOut   = 1'b0;
    result  = lhs_q;
    case (aluOp_q)
      OpAdd:        begin addB = rhs_q;  isArith = 1'b1; end
      OpAdc:        begin addB = rhs_q;  addC = ac_q; isArith = 1'b1; end
      OpSub, OpCmp: begin addB = ~rhs_q; addC = 1'b1; isArith = 1'b1; end
      OpSbc:        begin addB = ~rhs_q; addC = ac_q; isArith = 1'b1; end
      OpInc:        begin addC = 1'b1;   isArith = 1'b1; end
      OpDec:        begin addB = '1;     isArith = 1'b1; end
      OpAnd:        begin result = lhs_q & rhs_q; isLogic = 1'b1; end
      OpOr:         begin result = lhs_q | rhs_q; isLogic = 1'b1; end
      OpXor:        begin result = lhs_q ^ rhs_q; isLogic = 1'b1; end
      OpNot:        begin result = ~lhs_q; isLogic = 1'b1; end
      OpShl:        begin result = {lhs_q[WIDTH-2:0], 1'b0};  lcOut = lhs_q[WIDTH-1]; isLogic = 1'b1; end
      OpShr:        begin result = {1'b0, lhs_q[WIDTH-1:1]};  lcOut = lhs_q[0];       isLogic = 1'b1; end
      OpRol:        begin result = {lhs_q[WIDTH-2:0], lc_q};  lcOut = lhs_q[WIDTH-1]; isLogic = 1'b1; end
      OpRor:        begin result = {lc_q, lhs_q[WIDTH-1:1]};  lcOut = lhs_q[0];       isLogic = 1'b1; end
      default:      result = lhs_q;
    endcase
    sum = {1'b0, lhs_q} + {1'b0, addB} + {{WIDTH{1'b0}}, addC};
    if (isArith && aluOp_q != OpCmp) result = sum[WIDTH-1:0];
  end

  assign alu_result = result;
  assign flagSrc    = isArith ? sum[WIDTH-1:0] : result;
  assign aluOv      = (lhs_q[WIDTH-1] == addB[WIDTH-1]) && (sum[WIDTH-1] != lhs_q[WIDTH-1]);

  // Next-flag values; PASS and stalled cycles leave every flag as it was.
  always_comb begin
    updateFlags = !reset && !stall && (aluOp_q != OpPass);
    ov_d   = ov_q;
    ac_d   = ac_q;
    lc_d   = lc_q;
    sign_d = sign_q;
    zero_d = zero_q;
    if (updateFlags) begin
      sign_d = flagSrc[WIDTH-1];
      zero_d = (flagSrc == '0);
      if (isArith) begin
        ov_d = aluOv;
        ac_d = sum[WIDTH];
      end
      if (isLogic) lc_d = lcOut;
    end
  end

  always_comb begin
    load_enable   = '0;
    assert_enable = '0;
    if (!stall && xferLoad_q != 4'd0)   load_enable[xferLoad_q]     = 1'b1;
    if (!stall && xferAssert_q != 3'd0) assert_enable[xferAssert_q] = 1'b1;
  end

  // Stage register, flag register and the post-reset hold counter for flag_reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      aluOp_q      <= OpPass;
      xferLoad_q   <= '0;
      xferAssert_q <= '0;
      fetch_q      <= 1'b0;
      instr_q      <= '0;
      lhs_q        <= '0;
      rhs_q        <= '0;
      ov_q         <= 1'b0;
      sign_q       <= 1'b0;
      zero_q       <= 1'b0;
      ac_q         <= 1'b0;
      lc_q         <= 1'b0;
      pcra_q       <= 1'b0;
      frst_q       <= 1'b1;
      holdCnt_q    <= 4'(RESET_HOLD_CYCLES);
    end else begin
      frst_q <= (holdCnt_q != 4'd0);
      if (holdCnt_q != 4'd0) holdCnt_q <= holdCnt_q - 4'd1;
      ov_q   <= ov_d;
      sign_q <= sign_d;
      zero_q <= zero_d;
      ac_q   <= ac_d;
      lc_q   <= lc_d;
      if (!stall) begin
        if (xferLoad_q == 4'hF) pcra_q <= ~pcra_q;
        aluOp_q      <= aluOpE'(controls_in[7:4]);
        xferLoad_q   <= controls_in[11:8];
        xferAssert_q <= controls_in[14:12];
        fetch_q      <= controls_in[15];
        instr_q      <= instruction_in;
        lhs_q        <= lhs_data;
        rhs_q        <= rhs_data;
      end
    end
  end

  assign fetch_suppress  = fetch_q;
  assign instruction_out = instr_q;
  assign flag_pcraflip   = pcra_q;
  assign flag_reset      = frst_q;

`ifdef STAGE2_FLAG_BYPASS_EN
  assign flag_overflow = ov_d;
  assign flag_sign     = sign_d;
  assign flag_zero     = zero_d;
  assign flag_acarry   = ac_d;
  assign flag_lcarry   = lc_d;
`else
  assign flag_overflow = ov_q;
  assign flag_sign     = sign_q;
  assign flag_zero     = zero_q;
  assign flag_acarry   = ac_q;
  assign flag_lcarry   = lc_q;
`endif

endmodule
